// File: rtl/read_multi_pkg.sv
// rtl/read_multi_pkg.sv - shared pipeline types: word/op widths, flag bit order, read FSM states
package read_multi_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OP_W     = 8;

  typedef logic [XLEN_DEF-1:0] xword_t;
  typedef logic [OP_W-1:0]     op_t;

  // Flag vector bit order is C N V Z, Z in bit 0.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/read_multi_fwd_resolve.sv
// rtl/read_multi_fwd_resolve.sv - operand lookup with bypass priority and pc substitution
module fwd_resolve #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter int NFWD     = 2,
  parameter int PC_INDEX = NREGS - 1,
  parameter int RW       = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] registers,
  input  logic [RW-1:0]         index,
  input  logic [XLEN-1:0]       pc,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD*RW-1:0]    fwd_reg,
  input  logic [NFWD*XLEN-1:0]  fwd_value,
  output logic [XLEN-1:0]       value
);

  // Register file first, then bypass entries oldest to youngest so entry 0 wins; pc index overrides all.
  always_comb begin
    value = registers[index*XLEN +: XLEN];
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_reg[i*RW +: RW] == index)) begin
        value = fwd_value[i*XLEN +: XLEN];
      end
    end
    if (index == RW'(PC_INDEX)) begin
      value = pc;
    end
  end

endmodule

// File: rtl/read_multi.sv
// rtl/read_multi.sv - operand read stage with one outstanding memory read; READ_CX_EN enables compare-exchange adjust
module read_multi
  import read_multi_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter int NFWD     = 2,
  parameter int TIMEOUT  = 64,
  parameter int PC_INDEX = NREGS - 1,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREGS*XLEN-1:0] registers,
  input  logic                  in_valid,
  output logic                  in_hold,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [OP_W-1:0]       in_op,
  input  logic [RW-1:0]         in_target,
  input  logic [RW-1:0]         in_left,
  input  logic [RW-1:0]         in_right,
  input  logic [RW-1:0]         in_addr_reg,
  input  logic [XLEN-1:0]       in_adjust,
  input  logic                  in_rd_mem,
  input  logic                  in_wr_mem,
  input  logic [3:0]            in_mask,
  input  logic                  in_nz_active,
  input  logic [3:0]            flags,
  input  logic                  in_flushed,
  output logic                  early_flush,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD*RW-1:0]    fwd_reg,
  input  logic [NFWD*XLEN-1:0]  fwd_value,
  output logic                  mem_req,
  output logic [XLEN-1:0]       mem_address,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  out_valid,
  input  logic                  out_hold,
  output logic [XLEN-1:0]       out_pc,
  output logic [OP_W-1:0]       out_op,
  output logic [RW-1:0]         out_target,
  output logic [XLEN-1:0]       out_left,
  output logic [XLEN-1:0]       out_right,
  output logic [XLEN-1:0]       out_adjust,
  output logic                  out_wr_mem,
  output logic                  out_flushed,
  output logic                  out_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] left_val, right_val, addr_val;
  logic [XLEN-1:0] addr_q, adjust_next;
  logic            masked, active, v_q;
  logic            load_nm, load_mem, expired;

  fwd_resolve #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD), .PC_INDEX(PC_INDEX), .RW(RW)) u_left (
    .registers(registers), .index(in_left), .pc(in_pc), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_value(fwd_value), .value(left_val)
  );

  fwd_resolve #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD), .PC_INDEX(PC_INDEX), .RW(RW)) u_right (
    .registers(registers), .index(in_right), .pc(in_pc), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_value(fwd_value), .value(right_val)
  );

  fwd_resolve #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD), .PC_INDEX(PC_INDEX), .RW(RW)) u_addr (
    .registers(registers), .index(in_addr_reg), .pc(in_pc), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_value(fwd_value), .value(addr_val)
  );

  // Predicate evaluation, accept decisions and the compare-exchange adjust selection.
  always_comb begin
    masked   = |(in_mask & flags);
    active   = in_valid && (in_nz_active == masked);
    load_nm  = (state == S_IDLE) && active && !in_rd_mem && !out_hold;
    load_mem = (state == S_IDLE) && active && in_rd_mem && !out_hold;
    expired  = (cnt == CW'(TIMEOUT - 1));
`ifdef READ_CX_EN
    adjust_next = (in_rd_mem && in_wr_mem) ? right_val : in_adjust;
`else
    adjust_next = in_adjust;
`endif
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (load_mem) state_next = S_REQ;
      S_REQ:   if (mem_ack) state_next = S_WAIT;
      S_WAIT:  if (mem_valid || expired) state_next = S_DONE;
      S_DONE:  if (!out_hold) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs and handshakes.
  always_comb begin
    mem_req     = (state == S_REQ);
    mem_address = addr_q;
    out_valid   = (state == S_DONE) || ((state == S_IDLE) && v_q);
    in_hold     = in_valid && (out_hold || (state != S_IDLE) || (active && in_rd_mem));
    early_flush = in_flushed && in_valid && !active;
  end

  // Payload capture on accept, wait counter, and memory response / timeout capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      v_q         <= 1'b0;
      out_flushed <= 1'b0;
      out_fault   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!out_hold) begin
            v_q <= load_nm;
            if (load_nm || load_mem) begin
              out_pc      <= in_pc;
              out_op      <= in_op;
              out_target  <= in_target;
              out_left    <= left_val;
              out_right   <= right_val;
              out_adjust  <= adjust_next;
              out_wr_mem  <= in_wr_mem;
              out_flushed <= in_flushed && active;
              out_fault   <= 1'b0;
              addr_q      <= addr_val + in_adjust;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) cnt <= '0;
        end
        S_WAIT: begin
          if (mem_valid) begin
            out_right <= mem_data;
          end else if (expired) begin
            out_fault <= 1'b1;
            out_right <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_multi.sv
// tb/tb_read_multi.sv - directed self-checking bench for read_multi
module tb_read_multi;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NFWD  = 2;
  localparam int RW    = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREGS*XLEN-1:0] registers;
  logic                  in_valid, in_hold;
  logic [XLEN-1:0]       in_pc;
  logic [7:0]            in_op;
  logic [RW-1:0]         in_target, in_left, in_right, in_addr_reg;
  logic [XLEN-1:0]       in_adjust;
  logic                  in_rd_mem, in_wr_mem;
  logic [3:0]            in_mask, flags;
  logic                  in_nz_active, in_flushed, early_flush;
  logic [NFWD-1:0]       fwd_valid;
  logic [NFWD*RW-1:0]    fwd_reg;
  logic [NFWD*XLEN-1:0]  fwd_value;
  logic                  mem_req, mem_ack, mem_valid;
  logic [XLEN-1:0]       mem_address, mem_data;
  logic                  out_valid, out_hold;
  logic [XLEN-1:0]       out_pc, out_left, out_right, out_adjust;
  logic [7:0]            out_op;
  logic [RW-1:0]         out_target;
  logic                  out_wr_mem, out_flushed, out_fault;

  int checks = 0;
  int errors = 0;

  read_multi #(.XLEN(XLEN), .NREGS(NREGS), .NFWD(NFWD), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .registers(registers),
    .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc), .in_op(in_op),
    .in_target(in_target), .in_left(in_left), .in_right(in_right),
    .in_addr_reg(in_addr_reg), .in_adjust(in_adjust), .in_rd_mem(in_rd_mem),
    .in_wr_mem(in_wr_mem), .in_mask(in_mask), .in_nz_active(in_nz_active),
    .flags(flags), .in_flushed(in_flushed), .early_flush(early_flush),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_value(fwd_value),
    .mem_req(mem_req), .mem_address(mem_address), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data), .out_valid(out_valid),
    .out_hold(out_hold), .out_pc(out_pc), .out_op(out_op),
    .out_target(out_target), .out_left(out_left), .out_right(out_right),
    .out_adjust(out_adjust), .out_wr_mem(out_wr_mem),
    .out_flushed(out_flushed), .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; registers = '0;
    in_valid = 0; in_pc = '0; in_op = '0; in_target = '0; in_left = '0; in_right = '0;
    in_addr_reg = '0; in_adjust = '0; in_rd_mem = 0; in_wr_mem = 0; in_mask = '0;
    in_nz_active = 0; flags = '0; in_flushed = 0; fwd_valid = '0; fwd_reg = '0;
    fwd_value = '0; mem_ack = 0; mem_valid = 0; mem_data = '0; out_hold = 0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_out_flushed", out_flushed, 0);
    chk("rst_in_hold", in_hold, 0);
    reset = 1'b0;
    registers[2*XLEN +: XLEN] = 32'h100;
    registers[3*XLEN +: XLEN] = 32'd5;
    registers[4*XLEN +: XLEN] = 32'h44;

    // forwarding: entry 0 beats entry 1 beats register file
    in_valid = 1; in_pc = 32'h1000; in_op = 8'h12; in_target = 4'd5;
    in_left = 4'd3; in_right = 4'd4; in_adjust = 32'h20;
    fwd_valid = 2'b11; fwd_reg = {4'd3, 4'd3}; fwd_value = {32'd7, 32'd9};
    #1 chk("fwd_in_hold", in_hold, 0);
    tick();
    chk("fwd_out_valid", out_valid, 1);
    chk("fwd_left_r3", out_left, 9);
    chk("fwd_right_r4", out_right, 32'h44);
    chk("fwd_out_pc", out_pc, 32'h1000);
    chk("fwd_out_op", out_op, 8'h12);
    chk("fwd_out_target", out_target, 5);
    chk("fwd_out_adjust", out_adjust, 32'h20);

    // older bypass entry alone, pc index, flushed active slot
    fwd_valid = 2'b10; in_right = 4'd15; in_flushed = 1; in_pc = 32'h2000;
    tick();
    chk("fwd1_left_r3", out_left, 7);
    chk("pc_index_right", out_right, 32'h2000);
    chk("out_flushed_active", out_flushed, 1);
    in_valid = 0; in_flushed = 0; fwd_valid = '0;
    tick();
    chk("idle_out_valid", out_valid, 0);

    // memory read: ack on cycle 2, data on cycle 4, out_valid on cycle 5
    in_valid = 1; in_rd_mem = 1; in_addr_reg = 4'd2; in_adjust = 32'd4; in_left = 4'd3; in_right = 4'd4;
    #1 chk("rd_in_hold", in_hold, 1);
    tick();
    in_valid = 0; in_rd_mem = 0;
    chk("rd_c1_mem_req", mem_req, 1);
    chk("rd_c1_mem_address", mem_address, 32'h104);
    chk("rd_c1_out_valid", out_valid, 0);
    tick();
    mem_ack = 1;
    chk("rd_c2_mem_req", mem_req, 1);
    chk("rd_c2_mem_address", mem_address, 32'h104);
    tick();
    mem_ack = 0;
    chk("rd_c3_mem_req", mem_req, 0);
    chk("rd_c3_out_valid", out_valid, 0);
    tick();
    mem_valid = 1; mem_data = 32'hDEAD;
    chk("rd_c4_out_valid", out_valid, 0);
    tick();
    mem_valid = 0;
    chk("rd_c5_out_valid", out_valid, 1);
    chk("rd_c5_out_right", out_right, 32'hDEAD);
    chk("rd_c5_out_fault", out_fault, 0);
    chk("rd_c5_out_left", out_left, 5);

    // back-pressure in DONE for three cycles
    out_hold = 1; in_valid = 1; in_left = 4'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_right", out_right, 32'hDEAD);
      chk("bp_in_hold", in_hold, 1);
    end
    out_hold = 0; in_valid = 0;
    tick();
    chk("bp_release_out_valid", out_valid, 0);
    in_valid = 1;
    #1 chk("bp_release_in_hold", in_hold, 0);
    tick();
    chk("bp_next_out_valid", out_valid, 1);
    chk("bp_next_out_left", out_left, 32'h44);
    in_valid = 0;

    // timeout: fault four cycles after ack
    in_valid = 1; in_rd_mem = 1; in_addr_reg = 4'd2; in_adjust = 32'd8;
    tick();
    in_valid = 0; in_rd_mem = 0; mem_ack = 1;
    chk("to_mem_address", mem_address, 32'h108);
    tick();
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_out_valid", out_valid, 0);
    end
    tick();
    chk("to_out_fault", out_fault, 1);
    chk("to_out_right", out_right, 0);
    chk("to_out_valid", out_valid, 1);
    tick();
    chk("to_back_idle", out_valid, 0);

    // data arriving on the expiry cycle wins over the timeout
    in_valid = 1; in_rd_mem = 1;
    tick();
    in_valid = 0; in_rd_mem = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    tick(); tick(); tick();
    mem_valid = 1; mem_data = 32'hBEEF;
    tick();
    mem_valid = 0;
    chk("race_out_fault", out_fault, 0);
    chk("race_out_right", out_right, 32'hBEEF);
    chk("race_out_valid", out_valid, 1);
    tick();

    // predicated-off flushed slot
    in_valid = 1; in_mask = 4'b0001; flags = 4'b0001; in_nz_active = 0; in_flushed = 1;
    #1 chk("pred_early_flush", early_flush, 1);
    chk("pred_in_hold", in_hold, 0);
    tick();
    chk("pred_out_valid", out_valid, 0);
    in_nz_active = 1;
    #1 chk("pred_active_no_early_flush", early_flush, 0);
    in_valid = 0; in_mask = '0; flags = '0; in_nz_active = 0; in_flushed = 0;
    tick();

    // reset during WAIT, then a stray response
    in_valid = 1; in_rd_mem = 1;
    tick();
    in_valid = 0; in_rd_mem = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    reset = 1;
    tick();
    reset = 0; mem_valid = 1; mem_data = 32'h55;
    #1 chk("rstw_mem_req", mem_req, 0);
    tick();
    mem_valid = 0;
    chk("rstw_out_valid", out_valid, 0);
    tick();
    chk("rstw_out_valid_later", out_valid, 0);
    chk("rstw_mem_req_later", mem_req, 0);
    in_valid = 1;
    #1 chk("rstw_idle_in_hold", in_hold, 0);
    tick();
    chk("rstw_idle_accept", out_valid, 1);
    in_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
